// File: rtl/frame_loader_pkg.sv
// Shared globals for the frame loader slice.
// Holds the datapath widths, the 3-bit sequencer state encoding and the
// latched instruction record. There are no ports; the other files import it.
package frame_loader_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int REGADDR_WIDTH     = 5;
    localparam int RESLT_SELCT_WIDTH = 3;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD_A   = 3'd1;
    localparam state_t ST_RD_B   = 3'd2;
    localparam state_t ST_COMMIT = 3'd3;
    localparam state_t ST_HOLD   = 3'd4;

    typedef struct packed {
        logic [REGADDR_WIDTH-1:0]     aLoc;
        logic [REGADDR_WIDTH-1:0]     bLoc;
        logic [REGADDR_WIDTH-1:0]     writeSelect;
        logic [DATA_WIDTH-1:0]        imm;
        logic                         immSelect;
        logic                         isUnsigned;
        logic                         subtract;
        logic                         writeEnable;
        logic [RESLT_SELCT_WIDTH-1:0] resultSelect;
    } instr_t;

endpackage

// File: rtl/frame_loader_if.sv
// Decode-to-loader handshake bundle.
// master: the decode stage (drives dec_valid and the instruction fields).
// slave : the frame loader (drives dec_ready).
interface frame_loader_if;
    import frame_loader_pkg::*;

    logic                         dec_valid;
    logic                         dec_ready;
    logic [REGADDR_WIDTH-1:0]     dec_aLoc;
    logic [REGADDR_WIDTH-1:0]     dec_bLoc;
    logic [REGADDR_WIDTH-1:0]     dec_writeSelect;
    logic [DATA_WIDTH-1:0]        dec_imm;
    logic                         dec_immSelect;
    logic                         dec_unsigned;
    logic                         dec_subtract;
    logic                         dec_writeEnable;
    logic [RESLT_SELCT_WIDTH-1:0] dec_resultSelect;

    modport master (
        output dec_valid, dec_aLoc, dec_bLoc, dec_writeSelect, dec_imm,
               dec_immSelect, dec_unsigned, dec_subtract, dec_writeEnable,
               dec_resultSelect,
        input  dec_ready
    );

    modport slave (
        input  dec_valid, dec_aLoc, dec_bLoc, dec_writeSelect, dec_imm,
               dec_immSelect, dec_unsigned, dec_subtract, dec_writeEnable,
               dec_resultSelect,
        output dec_ready
    );

endinterface

// File: rtl/frame_loader_operand_bypass.sv
// Combinational operand resolver.
// Ports: loc (source register), rfData (register-file read data),
// wbEnable/wbAddr/wbData (writeback in flight), resolved (operand value).
// Register 0 always reads as zero; a same-cycle writeback to loc wins over
// the register file because the file has not absorbed it yet.
module frame_loader_operand_bypass
    import frame_loader_pkg::*;
(
    input  logic [REGADDR_WIDTH-1:0] loc,
    input  logic [DATA_WIDTH-1:0]    rfData,
    input  logic                     wbEnable,
    input  logic [REGADDR_WIDTH-1:0] wbAddr,
    input  logic [DATA_WIDTH-1:0]    wbData,
    output logic [DATA_WIDTH-1:0]    resolved
);

    always_comb begin
        resolved = rfData;
        if (loc == '0)
            resolved = '0;
        else if (wbEnable && (wbAddr == loc))
            resolved = wbData;
    end

endmodule

// File: rtl/frame_loader.sv
// Issue-side sequencer that fills the decode/execute frame.
// Ports: clk/reset; decIf (decode handshake, slave side); rf_readAddr /
// rf_readData (single RF read port, 1-cycle latency); wb_* (writeback bypass);
// flush (abort); exec_ack (frame consumed); frame_valid; *_in frame field
// data and *_we frame field write enables.
// Sequence: IDLE -> RD_A -> RD_B (A captured) -> COMMIT (rest captured) -> HOLD.
module frame_loader
    import frame_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    frame_loader_if.slave                decIf,
    output logic [REGADDR_WIDTH-1:0]     rf_readAddr,
    input  logic [DATA_WIDTH-1:0]        rf_readData,
    input  logic                         wb_enable,
    input  logic [REGADDR_WIDTH-1:0]     wb_addr,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         flush,
    input  logic                         exec_ack,
    output logic                         frame_valid,
    output logic [DATA_WIDTH-1:0]        aOperand_in,
    output logic [REGADDR_WIDTH-1:0]     aLoc_in,
    output logic [DATA_WIDTH-1:0]        bOperand_in,
    output logic [REGADDR_WIDTH-1:0]     bLoc_in,
    output logic [DATA_WIDTH-1:0]        immediateVal_in,
    output logic                         immediateSelect_in,
    output logic                         unsignedSelect_in,
    output logic                         subtractEnable_in,
    output logic [RESLT_SELCT_WIDTH-1:0] resultSelect_in,
    output logic [REGADDR_WIDTH-1:0]     writeSelect_in,
    output logic                         writeEnable_in,
    output logic                         aOperand_we,
    output logic                         aLoc_we,
    output logic                         bOperand_we,
    output logic                         bLoc_we,
    output logic                         imm_we,
    output logic                         immSlct_we,
    output logic                         unsigned_we,
    output logic                         subEnable_we,
    output logic                         resultSlct_we,
    output logic                         writeSlct_we,
    output logic                         writeEnable_we
);

    state_t state, nextState;
    instr_t instr;
    logic   accept;
    logic   weGate;

    assign accept = decIf.dec_valid && decIf.dec_ready;
    // Neither reset nor flush may leave a partial write in the frame.
    assign weGate = !reset && !flush;

    // Both resolvers see the same RF data; each is only used in its own
    // capture cycle (RD_B for A, COMMIT for B).
    frame_loader_operand_bypass bypassA (
        .loc(instr.aLoc), .rfData(rf_readData), .wbEnable(wb_enable),
        .wbAddr(wb_addr), .wbData(wb_data), .resolved(aOperand_in)
    );

    frame_loader_operand_bypass bypassB (
        .loc(instr.bLoc), .rfData(rf_readData), .wbEnable(wb_enable),
        .wbAddr(wb_addr), .wbData(wb_data), .resolved(bOperand_in)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (reset)
            instr <= '0;
        else if (accept)
            instr <= '{aLoc:         decIf.dec_aLoc,
                       bLoc:         decIf.dec_bLoc,
                       writeSelect:  decIf.dec_writeSelect,
                       imm:          decIf.dec_imm,
                       immSelect:    decIf.dec_immSelect,
                       isUnsigned:   decIf.dec_unsigned,
                       subtract:     decIf.dec_subtract,
                       writeEnable:  decIf.dec_writeEnable,
                       resultSelect: decIf.dec_resultSelect};
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (accept) nextState = ST_RD_A;
            ST_RD_A:   nextState = flush ? ST_IDLE : ST_RD_B;
            ST_RD_B:   nextState = flush ? ST_IDLE : ST_COMMIT;
            ST_COMMIT: nextState = flush ? ST_IDLE : ST_HOLD;
            ST_HOLD:   if (flush || exec_ack) nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        decIf.dec_ready    = 1'b0;
        rf_readAddr        = '0;
        frame_valid        = 1'b0;
        aLoc_in            = instr.aLoc;
        bLoc_in            = instr.bLoc;
        immediateVal_in    = instr.imm;
        immediateSelect_in = instr.immSelect;
        unsignedSelect_in  = instr.isUnsigned;
        subtractEnable_in  = instr.subtract;
        resultSelect_in    = instr.resultSelect;
        writeSelect_in     = instr.writeSelect;
        writeEnable_in     = instr.writeEnable;
        aOperand_we        = 1'b0;
        aLoc_we            = 1'b0;
        bOperand_we        = 1'b0;
        bLoc_we            = 1'b0;
        imm_we             = 1'b0;
        immSlct_we         = 1'b0;
        unsigned_we        = 1'b0;
        subEnable_we       = 1'b0;
        resultSlct_we      = 1'b0;
        writeSlct_we       = 1'b0;
        writeEnable_we     = 1'b0;
        case (state)
            ST_IDLE: decIf.dec_ready = weGate;
            ST_RD_A: rf_readAddr = instr.aLoc;
            ST_RD_B: begin
                rf_readAddr = instr.bLoc;
                aOperand_we = weGate;
                aLoc_we     = weGate;
            end
            ST_COMMIT: begin
                bOperand_we    = weGate && !instr.immSelect;
                bLoc_we        = weGate && !instr.immSelect;
                imm_we         = weGate && instr.immSelect;
                immSlct_we     = weGate;
                unsigned_we    = weGate;
                subEnable_we   = weGate;
                resultSlct_we  = weGate;
                writeSlct_we   = weGate;
                writeEnable_we = weGate;
            end
            ST_HOLD: begin
                frame_valid = weGate;
                // A flush while holding rewrites the frame's writeEnable to 0
                // so execute never retires the cancelled instruction.
                if (flush && !reset) begin
                    writeEnable_we = 1'b1;
                    writeEnable_in = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;
    import frame_loader_pkg::*;

    typedef struct {
        logic [31:0] aOp;
        logic [4:0]  aLoc;
        logic [31:0] bOp;
        logic [4:0]  bLoc;
        logic [31:0] imm;
        logic        immSel;
        logic        uns;
        logic        sub;
        logic        wrEn;
        logic [2:0]  resSel;
        logic [4:0]  wrSel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rf_readAddr;
    logic [31:0] rf_readData = '0;
    logic        wb_enable, flush, exec_ack, frame_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] aOperand_in, bOperand_in, immediateVal_in;
    logic [4:0]  aLoc_in, bLoc_in, writeSelect_in;
    logic [2:0]  resultSelect_in;
    logic        immediateSelect_in, unsignedSelect_in, subtractEnable_in, writeEnable_in;
    logic        aOperand_we, aLoc_we, bOperand_we, bLoc_we, imm_we, immSlct_we;
    logic        unsigned_we, subEnable_we, resultSlct_we, writeSlct_we, writeEnable_we;
    logic [10:0] weAll;

    logic [31:0] rfMem [32];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    frame_loader_if decIf ();

    frame_loader dut (
        .clk(clk), .reset(reset), .decIf(decIf),
        .rf_readAddr(rf_readAddr), .rf_readData(rf_readData),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .exec_ack(exec_ack), .frame_valid(frame_valid),
        .aOperand_in(aOperand_in), .aLoc_in(aLoc_in),
        .bOperand_in(bOperand_in), .bLoc_in(bLoc_in),
        .immediateVal_in(immediateVal_in), .immediateSelect_in(immediateSelect_in),
        .unsignedSelect_in(unsignedSelect_in), .subtractEnable_in(subtractEnable_in),
        .resultSelect_in(resultSelect_in), .writeSelect_in(writeSelect_in),
        .writeEnable_in(writeEnable_in),
        .aOperand_we(aOperand_we), .aLoc_we(aLoc_we), .bOperand_we(bOperand_we),
        .bLoc_we(bLoc_we), .imm_we(imm_we), .immSlct_we(immSlct_we),
        .unsigned_we(unsigned_we), .subEnable_we(subEnable_we),
        .resultSlct_we(resultSlct_we), .writeSlct_we(writeSlct_we),
        .writeEnable_we(writeEnable_we)
    );

    assign weAll = {aOperand_we, aLoc_we, bOperand_we, bLoc_we, imm_we, immSlct_we,
                    unsigned_we, subEnable_we, resultSlct_we, writeSlct_we, writeEnable_we};

    always #5 clk = ~clk;

    // Register file with one cycle of read latency.
    always @(posedge clk) rf_readData <= rfMem[rf_readAddr];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] resolve(input logic [4:0] loc, input logic wbE,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (loc == 5'd0) return 32'd0;
        if (wbE && wa == loc) return wd;
        return rfMem[loc];
    endfunction

    // Frame-write monitor: checks written fields against the scoreboard head.
    always @(negedge clk) begin
        if (weAll != '0) begin
            if (sb.size() == 0 && !(writeEnable_we && !immSlct_we)) begin
                chk("unexpected_we", {53'd0, weAll}, 64'd0);
            end else begin
                if (aOperand_we) begin
                    chk("aOperand", aOperand_in, sb[0].aOp);
                    chk("aLoc", aLoc_in, sb[0].aLoc);
                end
                if (immSlct_we) begin
                    if (bOperand_we) chk("bOperand", bOperand_in, sb[0].bOp);
                    if (bLoc_we) chk("bLoc", bLoc_in, sb[0].bLoc);
                    if (imm_we) chk("imm", immediateVal_in, sb[0].imm);
                    chk("ctrl", {immediateSelect_in, unsignedSelect_in, subtractEnable_in,
                                 writeEnable_in, resultSelect_in, writeSelect_in},
                        {sb[0].immSel, sb[0].uns, sb[0].sub, sb[0].wrEn,
                         sb[0].resSel, sb[0].wrSel});
                    void'(sb.pop_front());
                end else if (writeEnable_we) begin
                    chk("cancel_wrEn_in", writeEnable_in, 1'b0);
                end
            end
        end
    end

    // Accepts one instruction at the next edge and queues its expected frame.
    task automatic accept(input logic [4:0] a, b, ws, input logic [31:0] imm,
                          input logic immSel, uns, sub, wen, input logic [2:0] rs,
                          input logic wbE, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        e.aOp = resolve(a, 1'b0, 5'd0, 32'd0);
        e.bOp = resolve(b, wbE, wa, wd);
        e.aLoc = a; e.bLoc = b; e.imm = imm; e.immSel = immSel; e.uns = uns;
        e.sub = sub; e.wrEn = wen; e.resSel = rs; e.wrSel = ws;
        sb.push_back(e);
        @(posedge clk); #1;
        decIf.dec_valid = 1'b1; decIf.dec_aLoc = a; decIf.dec_bLoc = b;
        decIf.dec_writeSelect = ws; decIf.dec_imm = imm; decIf.dec_immSelect = immSel;
        decIf.dec_unsigned = uns; decIf.dec_subtract = sub;
        decIf.dec_writeEnable = wen; decIf.dec_resultSelect = rs;
        @(negedge clk);
        chk("idle_ready", decIf.dec_ready, 1'b1);
        @(posedge clk); #1;
        decIf.dec_valid = 1'b0;
    endtask

    task automatic runInstr(input logic [4:0] a, b, ws, input logic [31:0] imm,
                            input logic immSel, uns, sub, wen, input logic [2:0] rs,
                            input int hold, input logic wbE, input logic [4:0] wa,
                            input logic [31:0] wd);
        accept(a, b, ws, imm, immSel, uns, sub, wen, rs, wbE, wa, wd);
        exec_ack = 1'b1;  // ignored outside HOLD
        @(negedge clk);
        chk("rdA_addr", rf_readAddr, a);
        chk("rdA_we", weAll, 11'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdB_addr", rf_readAddr, b);
        chk("rdB_aWe", {aOperand_we, aLoc_we, bOperand_we}, 3'b110);
        @(posedge clk); #1;
        exec_ack = 1'b0;
        wb_enable = wbE; wb_addr = wa; wb_data = wd;
        @(negedge clk);
        chk("commit_we", weAll, {2'b00, ~immSel, ~immSel, immSel, 6'b111111});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            wb_enable = 1'b0;
            exec_ack = (k == hold - 1);
            @(negedge clk);
            chk("hold_fv_rdy", {frame_valid, decIf.dec_ready}, 2'b10);
        end
        @(posedge clk); #1;
        exec_ack = 1'b0;
        @(negedge clk);
        chk("after_ack", {frame_valid, decIf.dec_ready}, 2'b01);
    endtask

    // Aborts an instruction in the given cycle (1=RD_A .. 4=HOLD) by flush or reset.
    task automatic abortAt(input int phase, input logic useRst);
        accept(5'd3, 5'd5, 5'd9, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 5'd0, 32'd0);
        for (int cyc = 1; cyc <= phase; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (cyc == phase) begin
                if (useRst) reset = 1'b1; else flush = 1'b1;
            end
            @(negedge clk);
        end
        if (phase == 4 && !useRst) begin
            chk("flushHold_weEn", {writeEnable_we, writeEnable_in}, 2'b10);
            chk("flushHold_others", weAll[10:1], 10'd0);
            chk("flushHold_fv", frame_valid, 1'b0);
        end else begin
            chk(useRst ? "reset_we" : "flush_we", weAll, 11'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("abort_idle", {frame_valid, decIf.dec_ready}, 2'b01);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rfMem[i] = 32'h100 + i;
        rfMem[0] = 32'hDEAD; rfMem[3] = 32'd10; rfMem[5] = 32'd7;
        reset = 1'b1; flush = 1'b0; exec_ack = 1'b0;
        wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        decIf.dec_valid = 1'b0; decIf.dec_aLoc = '0; decIf.dec_bLoc = '0;
        decIf.dec_writeSelect = '0; decIf.dec_imm = '0; decIf.dec_immSelect = 1'b0;
        decIf.dec_unsigned = 1'b0; decIf.dec_subtract = 1'b0;
        decIf.dec_writeEnable = 1'b0; decIf.dec_resultSelect = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", decIf.dec_ready, 1'b0);
        chk("rst_we", weAll, 11'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state", {frame_valid, decIf.dec_ready, rf_readAddr}, {2'b01, 5'd0});

        // reg-reg add
        runInstr(5'd3, 5'd5, 5'd7, 32'h123, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1, 1'b0, 5'd0, 32'd0);
        // immediate
        runInstr(5'd4, 5'd6, 5'd8, 32'h1F, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1, 1'b0, 5'd0, 32'd0);
        // zero register on A, writeback bypass on B
        runInstr(5'd0, 5'd5, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1, 1'b1, 5'd5, 32'd99);
        // non-matching writeback leaves RF data in place; long backpressure
        runInstr(5'd12, 5'd5, 5'd31, 32'hABC, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 7, 1'b1, 5'd6, 32'd55);

        abortAt(1, 1'b0);
        abortAt(2, 1'b0);
        abortAt(3, 1'b0);
        abortAt(4, 1'b0);
        abortAt(3, 1'b1);

        // flush in IDLE blocks acceptance
        @(posedge clk); #1;
        flush = 1'b1; decIf.dec_valid = 1'b1;
        @(negedge clk);
        chk("idleFlush_ready", decIf.dec_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; decIf.dec_valid = 1'b0;
        @(negedge clk);
        chk("idleFlush_stay", {decIf.dec_ready, rf_readAddr}, {1'b1, 5'd0});

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
# frame_loader

Issue-side sequencer that writes the decode/execute instruction frame one field group at a time. Accepts one decoded instruction per valid/ready handshake and reads operands A and B through the single register-file read port, one after the other. Applies zero-register and writeback bypass rules to those operands. Drives the frame's per-field data and write-enable inputs, then holds `frame_valid` until execute acknowledges.

## Interface
Parameters: none. Widths come from the shared globals: `DATA_WIDTH`, `REGADDR_WIDTH`, `RESLT_SELCT_WIDTH`.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dec_valid` in 1 / `dec_ready` out 1: decode handshake.
- `dec_aLoc`, `dec_bLoc`, `dec_writeSelect` in `REGADDR_WIDTH`: source and destination register addresses.
- `dec_imm` in `DATA_WIDTH`; `dec_immSelect`, `dec_unsigned`, `dec_subtract`, `dec_writeEnable` in 1 each; `dec_resultSelect` in `RESLT_SELCT_WIDTH`.
- `rf_readAddr` out `REGADDR_WIDTH`; `rf_readData` in `DATA_WIDTH`: register-file read port; data returns 1 cycle after the address.
- `wb_enable` in 1; `wb_addr` in `REGADDR_WIDTH`; `wb_data` in `DATA_WIDTH`: writeback bypass source.
- `flush` in 1: synchronous abort.
- `exec_ack` in 1: execute has consumed the frame.
- `frame_valid` out 1: the frame holds a complete, unconsumed instruction.
- Frame drive: `aOperand_in`, `aLoc_in`, `bOperand_in`, `bLoc_in`, `immediateVal_in`, `immediateSelect_in`, `unsignedSelect_in`, `subtractEnable_in`, `resultSelect_in`, `writeSelect_in`, `writeEnable_in`. Widths match the frame fields.
- Frame write enables, 1 bit each: `aOperand_we`, `aLoc_we`, `bOperand_we`, `bLoc_we`, `imm_we`, `immSlct_we`, `unsigned_we`, `subEnable_we`, `resultSlct_we`, `writeSlct_we`, `writeEnable_we`.

## Operation
- States: IDLE, RD_A, RD_B, COMMIT, HOLD. Reset state is IDLE.
- IDLE
  - `dec_ready`=1 in IDLE only, and 0 while `reset` is high.
  - On `dec_valid` & `dec_ready`: latch all `dec_*` fields into an internal instruction register, then go to RD_A.
- RD_A
  - `rf_readAddr`=latched aLoc.
  - Go to RD_B.
- RD_B
  - `rf_readAddr`=latched bLoc.
  - Resolve A from `rf_readData` and assert `aOperand_we` and `aLoc_we`.
  - Go to COMMIT.
- COMMIT
  - Resolve B from `rf_readData`.
  - Assert `bOperand_we` and `bLoc_we` only when immSelect=0.
  - Assert `imm_we` only when immSelect=1.
  - Always assert `immSlct_we`, `unsigned_we`, `subEnable_we`, `resultSlct_we`, `writeSlct_we` and `writeEnable_we`.
  - Go to HOLD.
- HOLD
  - `frame_valid`=1.
  - On `exec_ack`, go to IDLE.
- Operand resolution, same rule for A and B:
  - loc==0 → 0.
  - else `wb_enable` & `wb_addr`==loc → `wb_data`.
  - else `rf_readData`.
  - Bypass is evaluated in the capture cycle (RD_B for A, COMMIT for B).
- Frame data outputs are driven from the instruction register and the resolved operands. Write enables are 0 in every cycle not listed above.
- Flush
  - In RD_A, RD_B or COMMIT: go to IDLE next edge. All write enables are suppressed in the flush cycle.
  - In HOLD: `writeEnable_we`=1 with `writeEnable_in`=0, cancelling the held instruction's writeback. `frame_valid`=0 in that cycle; go to IDLE.
  - In IDLE: `dec_ready`=0 and no accept.
  - Flush has priority over `exec_ack` and over `dec_valid`.
- Reset
  - Takes effect at the next edge from any state. All write enables are gated to 0 while `reset`=1.
  - Reset values: state IDLE; instruction register 0; `rf_readAddr`=0; `frame_valid`=0.

## Timing
- Accept at edge 0 → RD_A in cycle 1 → RD_B in cycle 2 (A written to the frame at edge 3) → COMMIT in cycle 3 (rest of the frame written at edge 4) → `frame_valid` high from cycle 4.
- Minimum issue interval is 5 cycles when `exec_ack` arrives in the first HOLD cycle. `dec_ready` returns in cycle 5.
- `exec_ack` outside HOLD is ignored.
- A writeback to the source register that lands in the capture cycle is forwarded. A writeback that lands in an earlier cycle is already in the register file.

## Structure
- The state encoding (3-bit localparams) is added to the shared globals include. Width macros are reused from there.
- One natural sub-module: `operand_bypass`, combinational: loc, rf data, wb enable/addr/data → resolved value. Instantiated twice, once for A and once for B.

## Test plan
- Reg-reg add: aLoc=3, bLoc=5, rf[3]=10, rf[5]=7, no wb → `aOperand_we` in cycle 2 with value 10; COMMIT shows `bOperand_in`=7 and all control enables; `frame_valid` from cycle 4.
- Immediate: immSelect=1, imm=0x1F → `imm_we`=1 and `bOperand_we`=`bLoc_we`=0 in COMMIT.
- Bypass/zero: wb_addr=5 and wb_data=99 during COMMIT with bLoc=5 → B=99; aLoc=0 with rf returning 0xDEAD → A=0.
- Backpressure: hold `exec_ack`=0 for 6 cycles → `frame_valid` stays 1 and `dec_ready` stays 0; ack → IDLE next cycle.
- Flush in HOLD → `writeEnable_we`=1 with `writeEnable_in`=0, `frame_valid` drops, IDLE next. Flush in RD_B → no write enables in that cycle.
- Reset asserted in COMMIT → all write enables 0 that cycle; next cycle IDLE with `frame_valid`=0 and `dec_ready`=1.
